// File: rtl/ahb_port_arbiter_if.sv
// Bundle of the two requester ports, the arbiter enable and the AHB-side command/response
// signals. The master modport is the arbiter; the slave modport is its environment.
interface ahb_port_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 3;

  logic              arb_en;

  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [SIZE_W-1:0] m0_size;
  logic              m0_ack;
  logic              m0_done;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [SIZE_W-1:0] m1_size;
  logic              m1_ack;
  logic              m1_done;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;

  logic              ahb_en;
  logic              ahb_wr_en;
  logic [ADDR_W-1:0] ahb_addr;
  logic [DATA_W-1:0] ahb_wr_data;
  logic [SIZE_W-1:0] ahb_data_size;
  logic [DATA_W-1:0] ahb_rd_data;
  logic              ahb_rd_vld;
  logic              ahb_busy;

  modport master (
    input  arb_en,
    input  m0_req, m0_wr, m0_addr, m0_wdata, m0_size,
    output m0_ack, m0_done, m0_err, m0_rdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata, m1_size,
    output m1_ack, m1_done, m1_err, m1_rdata,
    output ahb_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_data_size,
    input  ahb_rd_data, ahb_rd_vld, ahb_busy
  );

  modport slave (
    output arb_en,
    output m0_req, m0_wr, m0_addr, m0_wdata, m0_size,
    input  m0_ack, m0_done, m0_err, m0_rdata,
    output m1_req, m1_wr, m1_addr, m1_wdata, m1_size,
    input  m1_ack, m1_done, m1_err, m1_rdata,
    input  ahb_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_data_size,
    output ahb_rd_data, ahb_rd_vld, ahb_busy
  );
endinterface

// File: rtl/ahb_port_arbiter.sv
// Two-port round-robin arbiter in front of a single AHB command port with a WAIT watchdog.
// Every output is registered: ack/done/err/rdata appear the cycle after the accepting/completing edge.
module ahb_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst,
  ahb_port_arbiter_if.master bus
);
  localparam int unsigned WDOG_W = 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic              gnt;
  logic              last;
  logic [WDOG_W-1:0] wdog;

  logic any_req;
  logic pick;
  logic xfer_ok;
  logic expired;

  // Round-robin choice: on contention the port that was not granted last wins.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    pick    = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      pick = ~last;
    end else if (bus.m1_req) begin
      pick = 1'b1;
    end
  end

  // Writes finish on the first non-busy WAIT cycle; reads only on rd_vld.
  always_comb begin
    xfer_ok = bus.ahb_wr_en ? ~bus.ahb_busy : bus.ahb_rd_vld;
    expired = (wdog == WDOG_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      gnt               <= 1'b0;
      last              <= 1'b1;
      wdog              <= '0;
      bus.ahb_en        <= 1'b0;
      bus.ahb_wr_en     <= 1'b0;
      bus.ahb_addr      <= '0;
      bus.ahb_wr_data   <= '0;
      bus.ahb_data_size <= '0;
      bus.m0_ack        <= 1'b0;
      bus.m0_done       <= 1'b0;
      bus.m0_err        <= 1'b0;
      bus.m0_rdata      <= '0;
      bus.m1_ack        <= 1'b0;
      bus.m1_done       <= 1'b0;
      bus.m1_err        <= 1'b0;
      bus.m1_rdata      <= '0;
    end else begin
      bus.m0_ack  <= 1'b0;
      bus.m0_done <= 1'b0;
      bus.m0_err  <= 1'b0;
      bus.m1_ack  <= 1'b0;
      bus.m1_done <= 1'b0;
      bus.m1_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.arb_en && any_req) begin
            gnt               <= pick;
            bus.ahb_en        <= 1'b1;
            bus.ahb_wr_en     <= pick ? bus.m1_wr    : bus.m0_wr;
            bus.ahb_addr      <= pick ? bus.m1_addr  : bus.m0_addr;
            bus.ahb_wr_data   <= pick ? bus.m1_wdata : bus.m0_wdata;
            bus.ahb_data_size <= pick ? bus.m1_size  : bus.m0_size;
            state             <= ISSUE;
          end
        end

        ISSUE: begin
          if (!bus.ahb_busy) begin
            bus.ahb_en <= 1'b0;
            bus.m0_ack <= ~gnt;
            bus.m1_ack <= gnt;
            wdog       <= '0;
            state      <= WAIT;
          end
        end

        WAIT: begin
          // A response landing on the last watchdog cycle still counts as success.
          if (xfer_ok || expired) begin
            bus.m0_done <= ~gnt;
            bus.m1_done <= gnt;
            bus.m0_err  <= ~gnt & ~xfer_ok;
            bus.m1_err  <= gnt & ~xfer_ok;
            if (xfer_ok && !bus.ahb_wr_en) begin
              if (gnt) begin
                bus.m1_rdata <= bus.ahb_rd_data;
              end else begin
                bus.m0_rdata <= bus.ahb_rd_data;
              end
            end
            last  <= gnt;
            state <= IDLE;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end

        default: begin
          bus.ahb_en <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_port_arbiter.sv
// Directed bench for ahb_port_arbiter (TIMEOUT=4); the bench plays both requesters and the bus slave.
module tb_ahb_port_arbiter;
  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  int          n_checks;
  int          n_errors;
  int unsigned cyc = 0;
  logic [31:0] exp_rdata [2];

  ahb_port_arbiter_if bus ();

  ahb_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {m1_err, m1_done, m1_ack, m0_err, m0_done, m0_ack}
  function automatic logic [5:0] hs();
    return {bus.m1_err, bus.m1_done, bus.m1_ack, bus.m0_err, bus.m0_done, bus.m0_ack};
  endfunction

  task automatic set_req(input int p, input logic r, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size);
    if (p == 0) begin
      bus.m0_req = r; bus.m0_wr = wr; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_size = size;
    end else begin
      bus.m1_req = r; bus.m1_wr = wr; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_size = size;
    end
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!bus.ahb_en && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_grant"}, 32'(bus.ahb_en), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctl"},   32'({bus.ahb_en, bus.ahb_wr_en, bus.ahb_data_size}), 32'd0);
    check_eq({tag, "_addr"},  bus.ahb_addr, 32'd0);
    check_eq({tag, "_wdata"}, bus.ahb_wr_data, 32'd0);
    check_eq({tag, "_hs"},    32'(hs()), 32'd0);
    check_eq({tag, "_rd0"},   bus.m0_rdata, 32'd0);
    check_eq({tag, "_rd1"},   bus.m1_rdata, 32'd0);
  endtask

  // One complete transfer on port p: stall cycles of busy in ISSUE, wait_n non-completing WAIT cycles.
  task automatic xfer(input string tag, input int p, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] size, input int stall,
                      input int wait_n, input logic [31:0] rdata);
    int unsigned t0;
    t0 = cyc;
    set_req(p, 1'b1, wr, addr, wdata, size);
    wait_grant(tag);
    check_eq({tag, "_addr"},  bus.ahb_addr, addr);
    check_eq({tag, "_wdata"}, bus.ahb_wr_data, wdata);
    check_eq({tag, "_wrsz"},  32'({bus.ahb_wr_en, bus.ahb_data_size}), 32'({wr, size}));
    bus.ahb_busy = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq({tag, "_stall"},  32'({bus.ahb_en, hs()}), 32'h40);
      check_eq({tag, "_hold"},   bus.ahb_addr, addr);
    end
    bus.ahb_busy = 1'b0;
    tick();
    check_eq({tag, "_ack"}, 32'({bus.ahb_en, hs()}), (p != 0) ? 32'h08 : 32'h01);
    if (p == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
    bus.ahb_busy = 1'b1;
    if (wr) begin
      bus.ahb_rd_vld  = 1'b1;
      bus.ahb_rd_data = 32'hBAD0_0000;
    end
    for (int i = 0; i < wait_n; i++) begin
      tick();
      check_eq({tag, "_wait"}, 32'(hs()), 32'd0);
    end
    bus.ahb_busy = 1'b0;
    if (!wr) begin
      bus.ahb_rd_vld  = 1'b1;
      bus.ahb_rd_data = rdata;
      exp_rdata[p]    = rdata;
    end
    tick();
    check_eq({tag, "_done"},  32'({bus.ahb_en, hs()}), (p != 0) ? 32'h10 : 32'h02);
    check_eq({tag, "_rdata"}, (p != 0) ? bus.m1_rdata : bus.m0_rdata, exp_rdata[p]);
    check_eq({tag, "_lat"},   32'(cyc - t0), 32'(3 + stall + wait_n));
    bus.ahb_rd_vld = 1'b0;
    tick();
    check_eq({tag, "_idle"}, 32'({bus.ahb_en, hs()}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.arb_en = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    bus.ahb_rd_data = 32'd0;
    bus.ahb_rd_vld  = 1'b0;
    bus.ahb_busy    = 1'b0;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    tick();
    tick();
    check_zero("rst");
    rst = 1'b0;

    // Single read, write with backpressure, read completing on the watchdog's last cycle
    xfer("rd0",  0, 1'b0, 32'h0000_1000, 32'd0,         3'd2, 0, 2, 32'hDEAD_BEEF);
    xfer("bp",   1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 3'd1, 5, 1, 32'd0);
    xfer("edge", 0, 1'b0, 32'h0000_3000, 32'd0,         3'd2, 0, TO - 1, 32'h0BAD_F00D);

    // Read never answered -> error done after TO WAIT cycles; late rd_vld ignored
    set_req(0, 1'b1, 1'b0, 32'h0000_4000, 32'd0, 3'd2);
    wait_grant("to");
    bus.ahb_busy = 1'b0;
    tick();
    check_eq("to_ack", 32'({bus.ahb_en, hs()}), 32'h01);
    bus.m0_req   = 1'b0;
    bus.ahb_busy = 1'b1;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check_eq("to_wait", 32'(hs()), 32'd0);
    end
    tick();
    check_eq("to_err",   32'({bus.ahb_en, hs()}), 32'h06);
    check_eq("to_rdata", bus.m0_rdata, exp_rdata[0]);
    bus.ahb_busy    = 1'b0;
    bus.ahb_rd_vld  = 1'b1;
    bus.ahb_rd_data = 32'h5555_AAAA;
    tick();
    check_eq("late_hs",    32'({bus.ahb_en, hs()}), 32'd0);
    check_eq("late_rdata", bus.m0_rdata, exp_rdata[0]);
    bus.ahb_rd_vld = 1'b0;

    // Contention from reset with both requests held: m0, m1, m0, m1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 3'd2);
    set_req(1, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 3'd2);
    for (int g = 0; g < 4; g++) begin
      int p;
      p = g % 2;
      wait_grant("rr");
      check_eq("rr_addr", bus.ahb_addr, (p != 0) ? 32'h0000_0200 : 32'h0000_0100);
      bus.ahb_busy = 1'b0;
      tick();
      check_eq("rr_ack", 32'({bus.ahb_en, hs()}), (p != 0) ? 32'h08 : 32'h01);
      bus.ahb_busy = 1'b1;
      tick();
      bus.ahb_busy    = 1'b0;
      bus.ahb_rd_vld  = 1'b1;
      bus.ahb_rd_data = 32'h0000_00A0 + 32'(g);
      exp_rdata[p]    = 32'h0000_00A0 + 32'(g);
      tick();
      check_eq("rr_done",  32'({bus.ahb_en, hs()}), (p != 0) ? 32'h10 : 32'h02);
      check_eq("rr_rdata", (p != 0) ? bus.m1_rdata : bus.m0_rdata, exp_rdata[p]);
      bus.ahb_rd_vld = 1'b0;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();

    // Reset in WAIT of an m1 write after m0 was last granted
    xfer("pre", 0, 1'b0, 32'h0000_0500, 32'd0, 3'd2, 0, 0, 32'h1111_2222);
    set_req(1, 1'b1, 1'b1, 32'h0000_0600, 32'h0000_0077, 3'd2);
    wait_grant("rw");
    bus.ahb_busy = 1'b0;
    tick();
    check_eq("rw_ack", 32'({bus.ahb_en, hs()}), 32'h08);
    bus.m1_req   = 1'b0;
    bus.ahb_busy = 1'b1;
    tick();
    check_eq("rw_wait", 32'(hs()), 32'd0);
    rst = 1'b1;
    tick();
    check_zero("rst_wait");
    rst = 1'b0;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    bus.ahb_busy = 1'b0;
    tick();
    check_eq("rst_stale", 32'({bus.ahb_en, hs()}), 32'd0);
    set_req(0, 1'b1, 1'b0, 32'h0000_0700, 32'd0, 3'd2);
    set_req(1, 1'b1, 1'b0, 32'h0000_0800, 32'd0, 3'd2);
    wait_grant("post");
    check_eq("post_addr", bus.ahb_addr, 32'h0000_0700);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // arb_en gating: no grant while low; dropping it in WAIT lets the transfer finish
    bus.arb_en = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0000_0900, 32'd0, 3'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("gate_off", 32'({bus.ahb_en, hs()}), 32'd0);
    end
    bus.arb_en = 1'b1;
    wait_grant("gate_on");
    check_eq("gate_addr", bus.ahb_addr, 32'h0000_0900);
    set_req(1, 1'b1, 1'b0, 32'h0000_0A00, 32'd0, 3'd2);
    bus.ahb_busy = 1'b0;
    tick();
    check_eq("gate_ack", 32'({bus.ahb_en, hs()}), 32'h01);
    bus.m0_req   = 1'b0;
    bus.arb_en   = 1'b0;
    bus.ahb_busy = 1'b1;
    tick();
    bus.ahb_busy    = 1'b0;
    bus.ahb_rd_vld  = 1'b1;
    bus.ahb_rd_data = 32'h2468_2468;
    tick();
    check_eq("gate_done",  32'({bus.ahb_en, hs()}), 32'h02);
    check_eq("gate_rdata", bus.m0_rdata, 32'h2468_2468);
    bus.ahb_rd_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("gate_hold", 32'({bus.ahb_en, hs()}), 32'd0);
    end
    bus.m1_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ahb_port_arbiter.md
AHB_PORT_ARBITER -- requirements
Module: ahb_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum number of WAIT cycles before a transfer is aborted (range 1..255).
REQ-002 SHALL have one clock and a synchronous, active-high reset; the ports are listed below, clock and reset first.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- arb_en  in  1  1 = new grants allowed; 0 = in-flight transfer completes, no new grant
- mN_req  in  1  (N=0,1) level request, held with command stable until mN_ack
- mN_wr  in  1  1 = write, 0 = read
- mN_addr  in  32  byte address
- mN_wdata  in  32  write data
- mN_size  in  3  transfer size code, passed through unchanged
- mN_ack  out  1  one-cycle pulse: command accepted by bus
- mN_done  out  1  one-cycle pulse: transfer finished
- mN_err  out  1  valid with mN_done; 1 = timeout
- mN_rdata  out  32  read data, valid with mN_done for reads
- ahb_en  out  1  command valid
- ahb_wr_en  out  1  write qualifier
- ahb_addr  out  32  address
- ahb_wr_data  out  32  write data
- ahb_data_size  out  3  size code
- ahb_rd_data  in  32  read data
- ahb_rd_vld  in  1  read data valid pulse
- ahb_busy  in  1  bus cannot accept, or transfer in progress

Function
REQ-003 SHALL implement states IDLE, ISSUE, WAIT; all command outputs and ahb_* outputs SHALL be registered.
REQ-004 IDLE: when arb_en=1 and any mN_req=1, SHALL select a winner, latch its wr/addr/wdata/size into the ahb_* registers, and enter ISSUE on the next cycle; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin. With both requests present, the port not granted last wins. After reset, m0 is treated as "not last", so it wins.
REQ-006 ISSUE: ahb_en SHALL be 1. Acceptance is ahb_en=1 and ahb_busy=0 in the same cycle. On acceptance the module SHALL pulse the winner's mN_ack in that cycle and enter WAIT; while ahb_busy=1 it SHALL hold ISSUE with the command unchanged.
REQ-007 WAIT: ahb_en SHALL be 0. A read completes on the first ahb_rd_vld=1; a write completes on the first WAIT cycle with ahb_busy=0. The slave contract is that busy is asserted from the cycle after acceptance.
REQ-008 On completion the module SHALL, in the same cycle, pulse the winner's mN_done with mN_err=0, capture ahb_rd_data into mN_rdata (reads only), update the last-grant pointer, and return to IDLE.
REQ-009 An 8-bit watchdog SHALL clear on entry to WAIT and increment each WAIT cycle. When the count reaches TIMEOUT with no completion, the module SHALL pulse mN_done with mN_err=1, leave mN_rdata unchanged, and return to IDLE.
REQ-010 Simultaneous ahb_rd_vld and timeout SHALL count as normal completion (err=0).
REQ-011 ahb_rd_vld outside WAIT, or during a write, SHALL be ignored.
REQ-012 Minimum latency is 3 cycles from req to done: req seen in IDLE -> ISSUE accepted -> WAIT completes.
REQ-013 A new grant SHALL NOT be issued in the done cycle; IDLE is always visited for at least one cycle between transfers.
REQ-014 arb_en falling in ISSUE or WAIT SHALL NOT abort the current transfer.
REQ-015 The non-winning port SHALL see mN_ack=0 and mN_done=0 throughout.

Reset
REQ-016 On rst=1 at a clock edge: state=IDLE, last-grant pointer=m1, watchdog=0.
REQ-017 Under the same reset, all outputs SHALL be 0, including ahb_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_data_size, mN_ack, mN_done, mN_err and mN_rdata.
REQ-018 Reset asserted mid-ISSUE or mid-WAIT SHALL drop ahb_en the next cycle with no mN_done pulse; in-flight bus responses after reset SHALL be ignored.

Verification
REQ-019 Single read: m0 read addr 0x1000, slave busy 2 cycles then rd_vld with data 0xDEADBEEF -> one m0_ack, then m0_done with m0_rdata=0xDEADBEEF and m0_err=0.
REQ-020 Contention: m0 and m1 request together from reset -> m0 is served first, then m1. With both held continuously, grants alternate m0, m1, m0, m1.
REQ-021 Backpressure: ahb_busy=1 for 5 cycles during ISSUE -> ahb_en and the command stay stable for 5 cycles; ack comes on the 6th.
REQ-022 Timeout: TIMEOUT=4, read never answered -> done with err=1 after 4 WAIT cycles; then a late rd_vld -> ignored.
REQ-023 Reset during WAIT of an m1 write -> no m1_done, all outputs 0, and the next contention is granted to m0.
REQ-024 arb_en=0 with requests pending -> no ahb_en. arb_en dropped during WAIT -> the current transfer completes normally and no further grant follows.
